vgascope_capture_ctrl: RTL and testbench

Capture sequencer feeding the 6-trace VGA scope shift registers. Samples a 6-bit input bus at a programmable rate after an optional edge trigger, buffers samples in a small FIFO, and drains them into the scope push port only while the scope reports ready (outside the active display rows). Sits between the peripheral register file and the scope datapath inside the TinyQV peripheral, replacing software-driven pushes.

---
 rtl/vgascope_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_vgascope_capture_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vgascope_capture_ctrl.sv
// Capture sequencer: samples a 6-bit bus after an optional trigger into a FWFT FIFO drained by the scope.
// Define VGASCOPE_CAP_TRIGGER_EN to enable the edge trigger; otherwise ARMED fires on its first cycle.
module vgascope_capture_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       sample_in,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [6:0]       cfg_len,
   input  logic [2:0]       cfg_trig_ch,
   input  logic             cfg_trig_fall,
   input  logic             arm,
   input  logic             abort,
   input  logic             push_ready,
   output logic [5:0]       push_val,
   output logic             push_valid,
   output logic             busy,
   output logic             done,
   output logic             overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
   state_t state_reg, state_next;

   logic [5:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, count;
   logic [DIV_W-1:0] div_reg;
   logic [6:0]       rem_reg;
   logic             overflow_reg, done_reg, done_next;
   logic             fifo_empty, fifo_full, pop, sample_we, write_ok, fire, rem_last;

   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == PW'(FIFO_DEPTH));
   assign rem_last   = (rem_reg == 7'd1);

`ifdef VGASCOPE_CAP_TRIGGER_EN
   logic prev_reg, trig_bit;

   // Channels 6 and 7 select immediate trigger, so they never index the bus.
   assign trig_bit = (cfg_trig_ch < 3'd6) ? sample_in[cfg_trig_ch] : 1'b0;
   assign fire     = (cfg_trig_ch >= 3'd6) |
                     (cfg_trig_fall ? (prev_reg & ~trig_bit) : (~prev_reg & trig_bit));

   always_ff @(posedge clk) begin
      if (!rst_n)
         prev_reg <= 1'b0;
      else
         prev_reg <= trig_bit;
   end
`else
   logic unused_trig;

   assign unused_trig = ^{cfg_trig_ch, cfg_trig_fall};
   assign fire        = 1'b1;
`endif

   always_comb begin
      state_next = state_reg;
      sample_we  = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arm)
               state_next = ARMED;
         end
         ARMED: begin
            if (fire) begin
               sample_we  = 1'b1;
               state_next = rem_last ? FLUSH : CAPTURE;
            end
         end
         CAPTURE: begin
            if (div_reg >= cfg_div) begin
               sample_we = 1'b1;
               if (rem_last)
                  state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (fifo_empty) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
         sample_we  = 1'b0;
         done_next  = 1'b0;
      end
   end

   assign pop      = ~fifo_empty & push_ready & ~abort;
   // A full FIFO still takes the sample when the head leaves in the same cycle.
   assign write_ok = sample_we & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         div_reg      <= '0;
         rem_reg      <= '0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         if (abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (write_ok)
               wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (state_reg == IDLE && arm && !abort) begin
            rem_reg      <= (cfg_len == 7'd0) ? 7'd64 : cfg_len;
            overflow_reg <= 1'b0;
         end else if (sample_we) begin
            rem_reg <= rem_reg - 7'd1;
            if (!write_ok)
               overflow_reg <= 1'b1;
         end
         if (state_reg == CAPTURE && div_reg < cfg_div && !abort)
            div_reg <= div_reg + DIV_W'(1);
         else
            div_reg <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (write_ok)
         mem[wr_ptr_reg[AW-1:0]] <= sample_in;
   end

   assign push_valid = ~fifo_empty;
   assign push_val   = fifo_empty ? 6'd0 : mem[rd_ptr_reg[AW-1:0]];
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign overflow   = overflow_reg;
endmodule

// File: tb/tb_vgascope_capture_ctrl.sv
// Randomized bench for vgascope_capture_ctrl against a queue-based capture-schedule model.
module tb_vgascope_capture_ctrl;
   localparam int DEPTH = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    sample_in;
   logic [DW-1:0] cfg_div;
   logic [6:0]    cfg_len;
   logic [2:0]    cfg_trig_ch;
   logic          cfg_trig_fall;
   logic          arm, abort, push_ready;
   logic [5:0]    push_val;
   logic          push_valid, busy, done, overflow;

   always #5 clk = ~clk;

   vgascope_capture_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .cfg_div(cfg_div),
      .cfg_len(cfg_len), .cfg_trig_ch(cfg_trig_ch), .cfg_trig_fall(cfg_trig_fall),
      .arm(arm), .abort(abort), .push_ready(push_ready), .push_val(push_val),
      .push_valid(push_valid), .busy(busy), .done(done), .overflow(overflow)
   );

   int checks = 0;
   int errors = 0;

   // Model: captured samples waiting in the FIFO plus the capture schedule.
   int m_q[$];
   bit m_busy, m_wait, m_done, m_ovf, m_prev;
   int m_taken, m_len, m_fire, m_cyc;
   int n_pushes;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit a, input bit ab, input bit rdy, input logic [5:0] s);
      bit pop, wr, fire;
      bit bitv;
      pop    = (m_q.size() > 0) && rdy;
      m_done = 1'b0;
      wr     = 1'b0;
      bitv   = (cfg_trig_ch < 3'd6) ? s[cfg_trig_ch] : 1'b0;
      if (ab) begin
         m_q.delete();
         m_busy = 1'b0;
         m_wait = 1'b0;
      end else begin
         if (!m_busy) begin
            if (a) begin
               m_busy  = 1'b1;
               m_wait  = 1'b1;
               m_taken = 0;
               m_len   = (cfg_len == 7'd0) ? 64 : int'(cfg_len);
               m_ovf   = 1'b0;
            end
         end else if (m_wait) begin
            fire = 1'b1;
`ifdef VGASCOPE_CAP_TRIGGER_EN
            fire = (cfg_trig_ch >= 3'd6) || (cfg_trig_fall ? (m_prev && !bitv) : (!m_prev && bitv));
`endif
            if (fire) begin
               m_wait = 1'b0;
               m_fire = m_cyc;
               wr     = 1'b1;
            end
         end else if (m_taken < m_len) begin
            if ((m_cyc - m_fire) % (int'(cfg_div) + 1) == 0)
               wr = 1'b1;
         end else if (m_q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
         if (pop) begin
            void'(m_q.pop_front());
            n_pushes++;
         end
         if (wr) begin
            m_taken++;
            if (m_q.size() < DEPTH)
               m_q.push_back(int'(s));
            else
               m_ovf = 1'b1;
         end
      end
      m_prev = bitv;
      m_cyc++;
   endtask

   task automatic step(input bit a, input bit ab, input bit rdy, input logic [5:0] s);
      arm        = a;
      abort      = ab;
      push_ready = rdy;
      sample_in  = s;
      model_edge(a, ab, rdy, s);
      @(posedge clk);
      #1;
      check_val("push_valid", push_valid, m_q.size() > 0);
      check_val("push_val", push_val, (m_q.size() > 0) ? m_q[0] : 0);
      check_val("busy", busy, m_busy);
      check_val("done", done, m_done);
      check_val("overflow", overflow, m_ovf);
   endtask

   initial begin
      int kind, ready_mode, abort_at, c;
      bit a, ab, rdy;
      logic [5:0] s;

      rst_n = 1'b0;
      arm = 1'b0; abort = 1'b0; push_ready = 1'b0; sample_in = '0;
      cfg_div = '0; cfg_len = 7'd1; cfg_trig_ch = 3'd7; cfg_trig_fall = 1'b0;
      m_busy = 0; m_wait = 0; m_done = 0; m_ovf = 0; m_prev = 0;
      m_taken = 0; m_len = 0; m_fire = 0; m_cyc = 0; n_pushes = 0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_push_valid", push_valid, 0);
      check_val("rst_push_val", push_val, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_overflow", overflow, 0);
      rst_n = 1'b1;

      for (int ep = 0; ep < 40; ep++) begin
         kind     = (ep < 5) ? ep : int'($urandom_range(4, 6));
         abort_at = -1;
         case (kind)
            0: begin cfg_div = 3; cfg_len = 5; cfg_trig_ch = 7; ready_mode = 0; end
            1: begin cfg_div = 0; cfg_len = 20; cfg_trig_ch = 7; ready_mode = 1; end
            2: begin cfg_div = DW'($urandom_range(0, 1)); cfg_len = 0; cfg_trig_ch = 3'($urandom_range(0, 7)); ready_mode = 3; end
            3: begin cfg_div = 1; cfg_len = 8; cfg_trig_ch = 2; cfg_trig_fall = 0; ready_mode = 0; end
            4: begin cfg_div = 0; cfg_len = 10; cfg_trig_ch = 7; ready_mode = 1; abort_at = 8; end
            default: begin
               cfg_div       = DW'($urandom_range(0, 4));
               cfg_len       = 7'($urandom_range(0, 64));
               cfg_trig_ch   = 3'($urandom_range(0, 7));
               cfg_trig_fall = 1'($urandom_range(0, 1));
               ready_mode    = int'($urandom_range(0, 3));
               if ($urandom_range(0, 3) == 0)
                  abort_at = int'($urandom_range(2, 40));
            end
         endcase
         n_pushes = 0;
         for (c = 0; c < 1500; c++) begin
            a  = (c == 0) || (m_busy && $urandom_range(0, 40) == 0);
            ab = (c == abort_at);
            case (ready_mode)
               0: rdy = 1'b1;
               1: rdy = (c >= 40);
               2: rdy = 1'($urandom_range(0, 1));
               default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (kind == 0) begin
               s = 6'(c);
            end else begin
               s = 6'($urandom);
               if (kind == 3)
                  s[2] = (c < 6) ? 1'b1 : (c < 9) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            step(a, ab, rdy, s);
            if (c > 2 && !m_busy && m_q.size() == 0)
               break;
         end
         if (m_busy || m_q.size() != 0)
            step(1'b0, 1'b1, 1'b0, 6'd0);
         $display("episode %0d kind %0d div %0d len %0d cycles %0d pushes %0d overflow %0d",
                  ep, kind, cfg_div, cfg_len, c, n_pushes, m_ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
